// File: rtl/gba_prefetch_pkg.sv
// Shared types for the cart-ROM prefetcher.
//   pf_state_t : request-side state machine states
//   pf_tag_t   : 64-bit word tag, byte address bits [27:3]
//   pf_hw_sel  : pick halfword k (data[16k+15:16k]) out of a 64-bit word
package gba_prefetch_pkg;

    typedef enum logic [1:0] {STREAM, MISS_WAIT, IDLE_FLUSH} pf_state_t;

    typedef logic [27:3] pf_tag_t;

    localparam int HW_PER_WORD = 4;

    function automatic logic [15:0] pf_hw_sel(input logic [63:0] w, input logic [1:0] k);
        logic [15:0] r;
        r = w[15:0];
        for (int i = 0; i < HW_PER_WORD; i++)
            if (k == 2'(i)) r = w[16*i +: 16];
        return r;
    endfunction

endpackage

// File: rtl/gba_prefetch_fifo.sv
// Synchronous FIFO of {tag, 64-bit data} words for the ROM prefetcher.
//   i_clk, i_reset  : clock, synchronous active-high reset
//   i_clear         : drop all entries (wins over push/pop in the same cycle)
//   i_push, i_push_tag, i_push_data : write one entry
//   i_pop           : number of entries to retire this cycle (0, 1 or 2)
//   o_head_*        : oldest entry, o_next_* : the one behind it
//   o_count         : number of valid entries
module gba_prefetch_fifo
    import gba_prefetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                      i_clk,
    input  logic                      i_reset,
    input  logic                      i_clear,
    input  logic                      i_push,
    input  logic [24:0]               i_push_tag,
    input  logic [63:0]               i_push_data,
    input  logic [1:0]                i_pop,
    output logic [24:0]               o_head_tag,
    output logic [63:0]               o_head_data,
    output logic [24:0]               o_next_tag,
    output logic [63:0]               o_next_data,
    output logic [$clog2(DEPTH):0]    o_count
);
    localparam int AW = $clog2(DEPTH);

    logic [24:0]   r_tag  [DEPTH];
    logic [63:0]   r_data [DEPTH];
    logic [AW-1:0] r_rd_ptr;
    logic [AW-1:0] r_wr_ptr;
    logic [AW:0]   r_count;
    logic [AW-1:0] w_rd_ptr1;

    // DEPTH is a power of two, so pointers wrap by plain overflow.
    assign w_rd_ptr1 = r_rd_ptr + 1'b1;

    always_ff @(posedge i_clk) begin
        if (i_reset || i_clear) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
        end else begin
            r_wr_ptr <= r_wr_ptr + AW'(i_push);
            r_rd_ptr <= r_rd_ptr + AW'(i_pop);
            r_count  <= r_count + (AW+1)'(i_push) - (AW+1)'(i_pop);
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_push) begin
            r_tag[r_wr_ptr]  <= i_push_tag;
            r_data[r_wr_ptr] <= i_push_data;
        end
    end

    assign o_head_tag  = r_tag[r_rd_ptr];
    assign o_head_data = r_data[r_rd_ptr];
    assign o_next_tag  = r_tag[w_rd_ptr1];
    assign o_next_data = r_data[w_rd_ptr1];
    assign o_count     = r_count;

endmodule

// File: rtl/gba_rom_prefetch.sv
// Sequential cart-ROM prefetcher in front of ddram channel 1.
// CPU halfword fetches are served from a FIFO of aligned 64-bit words that the
// fetcher keeps filling ahead of the CPU; any non-sequential fetch restarts the stream.
//   i_clk, i_reset        : clock (ddram clock), synchronous active-high reset
//   i_rd_addr[27:1]       : halfword fetch address, sampled with i_rd_req
//   i_rd_req, i_flush     : fetch pulse; drop everything (ROM reload / cart swap)
//   o_rd_data, o_rd_valid : fetched halfword (held) and its 1-cycle strobe
//   o_mem_addr[27:1], o_mem_req, o_mem_rnw : ch1 read request (8-byte aligned, read only)
//   i_mem_dout, i_mem_ready : ch1 read data and completion pulse
module gba_rom_prefetch
    import gba_prefetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic         i_clk,
    input  logic         i_reset,
    input  logic [27:1]  i_rd_addr,
    input  logic         i_rd_req,
    input  logic         i_flush,
    output logic [15:0]  o_rd_data,
    output logic         o_rd_valid,
    output logic [27:1]  o_mem_addr,
    output logic         o_mem_req,
    output logic         o_mem_rnw,
    input  logic [63:0]  i_mem_dout,
    input  logic         i_mem_ready
);
    localparam int AW = $clog2(DEPTH);

    pf_state_t   r_state;
    pf_tag_t     r_fetch_tag;
    pf_tag_t     r_inflight_tag;
    logic        r_outstanding;
    logic        r_drop;
    logic [1:0]  r_want_k;
    logic [15:0] r_rd_data;
    logic        r_rd_valid;
    logic        r_mem_req;
    logic [27:1] r_mem_addr;

    logic [24:0] w_head_tag, w_next_tag;
    logic [63:0] w_head_data, w_next_data;
    logic [AW:0] w_count;
    pf_tag_t     w_t;
    logic [1:0]  w_k, w_arr_k;
    logic        w_req_stream, w_hit0, w_hit1, w_pend, w_miss, w_clear;
    logic        w_accept, w_arrive_serve, w_push, w_fetch;
    logic [1:0]  w_pop;

    assign w_t = i_rd_addr[27:3];
    assign w_k = i_rd_addr[2:1];

    // Hit/miss decisions look at the FIFO as it stood before this cycle's push/pop.
    assign w_req_stream = i_rd_req && !i_flush && (r_state == STREAM);
    assign w_hit0 = w_req_stream && (w_count != '0) && (w_t == w_head_tag);
    assign w_hit1 = w_req_stream && !w_hit0 && (w_count >= (AW+1)'(2))
                    && (w_t == pf_tag_t'(w_head_tag + 25'd1));
    assign w_pend = w_req_stream && (w_count == '0) && r_outstanding && !r_drop
                    && (w_t == r_inflight_tag);
    assign w_miss  = i_rd_req && !(w_hit0 || w_hit1 || w_pend);
    assign w_clear = w_miss || i_flush;

    // A reply landing in a clearing cycle belongs to the old stream and is thrown away.
    assign w_accept = i_mem_ready && r_outstanding && !r_drop && !w_clear;

    // The word the CPU is waiting on arrives: answer straight from i_mem_dout.
    // The FIFO is empty here, so a k==3 fetch simply skips the push instead of push+pop.
    assign w_arrive_serve = w_accept && ((r_state == MISS_WAIT) || w_pend);
    assign w_arr_k        = (r_state == MISS_WAIT) ? r_want_k : w_k;
    assign w_push = w_accept && !(w_arrive_serve && (w_arr_k == 2'(HW_PER_WORD-1)));

    always_comb begin
        w_pop = 2'd0;
        if (w_hit0)
            w_pop = (w_k == 2'(HW_PER_WORD-1)) ? 2'd1 : 2'd0;
        else if (w_hit1)
            w_pop = (w_k == 2'(HW_PER_WORD-1)) ? 2'd2 : 2'd1;
    end

    // Held off during a clearing cycle so a request from the old stream is never issued
    // after fetch_tag has been retargeted.
    assign w_fetch = !r_outstanding && (w_count < (AW+1)'(DEPTH)) && !r_drop
                     && (r_state != IDLE_FLUSH) && !w_clear;

    gba_prefetch_fifo #(.DEPTH(DEPTH)) u_fifo (
        .i_clk       (i_clk),
        .i_reset     (i_reset),
        .i_clear     (w_clear),
        .i_push      (w_push),
        .i_push_tag  (r_inflight_tag),
        .i_push_data (i_mem_dout),
        .i_pop       (w_pop),
        .o_head_tag  (w_head_tag),
        .o_head_data (w_head_data),
        .o_next_tag  (w_next_tag),
        .o_next_data (w_next_data),
        .o_count     (w_count)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state        <= STREAM;
            r_fetch_tag    <= '0;
            r_inflight_tag <= '0;
            r_want_k       <= '0;
            r_rd_data      <= '0;
            r_rd_valid     <= 1'b0;
            r_mem_req      <= 1'b0;
            r_mem_addr     <= '0;
            // ddram keeps running through our reset: a pending read must still be
            // waited for, and its reply discarded.
            r_outstanding  <= r_outstanding && !i_mem_ready;
            r_drop         <= r_outstanding && !i_mem_ready;
        end else begin
            r_rd_valid <= 1'b0;
            r_mem_req  <= 1'b0;

            if (w_fetch) begin
                r_mem_req      <= 1'b1;
                r_mem_addr     <= {r_fetch_tag, 2'b00};
                r_inflight_tag <= r_fetch_tag;
                r_fetch_tag    <= r_fetch_tag + 25'd1;
                r_outstanding  <= 1'b1;
            end else if (i_mem_ready) begin
                r_outstanding <= 1'b0;
                r_drop        <= 1'b0;
            end

            if (w_clear)
                r_drop <= r_outstanding && !i_mem_ready;

            if (w_miss) begin
                r_fetch_tag <= w_t;
                r_want_k    <= w_k;
                r_state     <= MISS_WAIT;
            end else if (i_flush) begin
                r_state <= IDLE_FLUSH;
            end else if (w_pend && !w_arrive_serve) begin
                r_want_k <= w_k;
                r_state  <= MISS_WAIT;
            end else if (w_arrive_serve) begin
                r_state <= STREAM;
            end

            if (w_hit0) begin
                r_rd_data  <= pf_hw_sel(w_head_data, w_k);
                r_rd_valid <= 1'b1;
            end else if (w_hit1) begin
                r_rd_data  <= pf_hw_sel(w_next_data, w_k);
                r_rd_valid <= 1'b1;
            end else if (w_arrive_serve) begin
                r_rd_data  <= pf_hw_sel(i_mem_dout, w_arr_k);
                r_rd_valid <= 1'b1;
            end
        end
    end

    assign o_rd_data  = r_rd_data;
    assign o_rd_valid = r_rd_valid;
    assign o_mem_addr = r_mem_addr;
    assign o_mem_req  = r_mem_req;
    assign o_mem_rnw  = 1'b1;

endmodule

// File: tb/tb_gba_rom_prefetch.sv
// Bench for gba_rom_prefetch: a ROM whose halfword contents are a hash of the byte
// address and a "cartridge" seed, a ddram responder with random latency, and a
// scoreboard that compares every rd_valid against the ROM contents of the requested
// address. The seed changes on every flush/reset, so stale replies cannot match.
module tb_gba_rom_prefetch;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [27:1] rd_addr = '0;
    logic        rd_req = 1'b0;
    logic        flush = 1'b0;
    logic [15:0] rd_data;
    logic        rd_valid;
    logic [27:1] mem_addr;
    logic        mem_req;
    logic        mem_rnw;
    logic [63:0] mem_dout = '0;
    logic        mem_ready = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [15:0] seed = 16'h1234;

    typedef struct {
        logic [15:0] d;
        logic [27:0] a;
        int          issue;
        int          mode;   // 0 data only, 1 hit latency, 2 served on the arrival edge
    } exp_t;

    exp_t        expq[$];
    exp_t        mon_e;
    logic [27:0] req_log[$];
    int          ready_cyc = -100;
    int          force_delay = 0;
    bit          busy = 1'b0;
    int          dly = 0;
    logic [63:0] rsp_data = '0;
    logic [27:0] rsp_a = '0;
    logic [27:0] a = '0;
    bit          ok;

    gba_rom_prefetch #(.DEPTH(DEPTH)) dut (
        .i_clk       (clk),
        .i_reset     (reset),
        .i_rd_addr   (rd_addr),
        .i_rd_req    (rd_req),
        .i_flush     (flush),
        .o_rd_data   (rd_data),
        .o_rd_valid  (rd_valid),
        .o_mem_addr  (mem_addr),
        .o_mem_req   (mem_req),
        .o_mem_rnw   (mem_rnw),
        .i_mem_dout  (mem_dout),
        .i_mem_ready (mem_ready)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // ROM contents: an odd multiplier keeps neighbouring halfwords distinct.
    function automatic logic [15:0] hw(input logic [27:0] ba, input logic [15:0] s);
        logic [15:0] lo;
        lo = ba[16:1];
        return (lo * 16'h9E37) ^ {5'b0, ba[27:17]} ^ s;
    endfunction

    function automatic logic [63:0] rom_word(input logic [27:0] ba, input logic [15:0] s);
        logic [63:0] w;
        for (int k = 0; k < 4; k++)
            w[16*k +: 16] = hw({ba[27:3], 2'(k), 1'b0}, s);
        return w;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %h required %h", nm, act, exp);
        end
    endtask

    task automatic done();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    endtask

    // ddram channel 1: one read at a time, reply after 1..6 cycles (or force_delay).
    initial begin
        forever begin
            @(posedge clk); #1;
            mem_ready = 1'b0;
            if (busy) begin
                dly--;
                if (dly == 0) begin
                    mem_ready = 1'b1;
                    mem_dout  = rsp_data;
                    busy      = 1'b0;
                end
            end
            if (mem_req) begin
                rsp_a = {mem_addr, 1'b0};
                req_log.push_back(rsp_a);
                chk("mem_align", 32'(rsp_a[2:0]), 32'd0);
                chk("mem_rnw", 32'(mem_rnw), 32'd1);
                chk("one_outstanding", 32'(busy), 32'd0);
                busy     = 1'b1;
                dly      = (force_delay != 0) ? force_delay : int'($urandom_range(1, 6));
                rsp_data = rom_word(rsp_a, seed);
            end
        end
    end

    // Scoreboard monitor.
    always @(negedge clk) begin
        if (mem_ready) ready_cyc = cyc;
        if (!reset && rd_valid) begin
            if (expq.size() == 0) begin
                chk("spurious_rd_valid", 32'd1, 32'd0);
            end else begin
                mon_e = expq.pop_front();
                chk($sformatf("rd_data@%h", mon_e.a), 32'(rd_data), 32'(mon_e.d));
                if (mon_e.mode == 1) chk("hit_latency", 32'(cyc - mon_e.issue), 32'd1);
                if (mon_e.mode == 2) chk("arrival_latency", 32'(cyc - ready_cyc), 32'd1);
            end
        end
    end

    initial begin
        #500000;
        chk("watchdog", 32'd1, 32'd0);
        done();
    end

    // Drives one fetch (optionally with flush, which also swaps the cartridge).
    // Also releases reset, so a fetch can land on the first cycle out of reset.
    task automatic issue(input logic [27:0] ba, input bit with_flush, input int mode);
        @(posedge clk); #1;
        reset = 1'b0;
        if (with_flush) seed = seed + 16'h3B1;
        rd_addr = ba[27:1];
        rd_req  = 1'b1;
        flush   = with_flush;
        expq.push_back('{hw(ba, seed), ba, cyc, mode});
        @(posedge clk); #1;
        rd_req = 1'b0;
        flush  = 1'b0;
    endtask

    task automatic wait_resp();
        int n;
        n = 0;
        while (expq.size() != 0 && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (expq.size() != 0) begin
            chk("resp_timeout", 32'(expq.size()), 32'd0);
            done();
        end
    endtask

    task automatic do_flush();
        @(posedge clk); #1;
        seed  = seed + 16'h3B1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
    endtask

    // Leaves reset asserted; the next issue() releases it.
    task automatic do_reset(input int n);
        @(posedge clk); #1;
        reset = 1'b1;
        seed  = seed + 16'h5A5;
        expq.delete();
        repeat (n) @(posedge clk);
        @(negedge clk);
        chk("reset_rd_valid", 32'(rd_valid), 32'd0);
        chk("reset_rd_data", 32'(rd_data), 32'd0);
        chk("reset_mem_req", 32'(mem_req), 32'd0);
        chk("reset_mem_addr", 32'(mem_addr), 32'd0);
        req_log.delete();
    endtask

    function automatic int log_count(input logic [27:0] ba);
        int c;
        c = 0;
        foreach (req_log[i]) if (req_log[i] == ba) c++;
        return c;
    endfunction

    initial begin
        do_reset(3);

        // Cold start: one miss, then the fetcher fills DEPTH words and stops.
        issue(28'h100, 1'b0, 2);
        wait_resp();
        repeat (60) @(posedge clk);
        #1;
        chk("cold_req_count", 32'(req_log.size()), 32'd4);
        for (int i = 0; i < 4; i++)
            if (i < req_log.size())
                chk($sformatf("cold_req%0d", i), 32'(req_log[i]), 32'h100 + 32'(8 * i));

        // Sequential halfwords all hit with 1-cycle latency; popping refills from 0x120.
        for (int i = 0; i < 16; i++) begin
            issue(28'h100 + 28'(2 * i), 1'b0, 1);
            wait_resp();
        end
        repeat (30) @(posedge clk);
        #1;
        chk("refill_req", (req_log.size() > 4) ? 32'(req_log[4]) : 32'hDEAD, 32'h120);

        // Jump away while the stream has a read in flight, then catch a pending word.
        force_delay = 6;
        issue(28'h8000, 1'b0, 0);
        wait_resp();
        issue(28'h8006, 1'b0, 1);
        wait_resp();
        issue(28'h8008, 1'b0, 2);
        wait_resp();
        repeat (10) @(posedge clk);
        #1;
        chk("pend_single_req", 32'(log_count(28'h8008)), 32'd1);

        // Reset with a read outstanding: its late reply must never be used.
        force_delay = 10;
        issue(28'h20000, 1'b0, 0);
        ok = 1'b0;
        for (int n = 0; n < 60 && !ok; n++) begin
            if (log_count(28'h20000) != 0) ok = 1'b1;
            else begin @(posedge clk); #1; end
        end
        chk("pre_reset_req_seen", 32'(ok), 32'd1);
        force_delay = 0;
        do_reset(2);
        issue(28'h20000, 1'b0, 0);
        wait_resp();
        chk("post_reset_fresh_req", (req_log.size() > 0) ? 32'(req_log[0]) : 32'hDEAD, 32'h20000);

        // Flush together with a fetch of the last word of the address space: tag wraps.
        issue(28'hFFFFFFE, 1'b1, 0);
        wait_resp();
        repeat (20) @(posedge clk);
        #1;
        ok = 1'b0;
        for (int i = 0; i + 1 < req_log.size(); i++)
            if (req_log[i] == 28'hFFFFFF8 && req_log[i+1] == 28'h0) ok = 1'b1;
        chk("tag_wrap_to_zero", 32'(ok), 32'd1);

        // Random mix of sequential runs, intra-word accesses, jumps and flushes.
        a = 28'h400;
        for (int n = 0; n < 250; n++) begin
            int  r;
            bit  fl;
            r  = int'($urandom_range(0, 99));
            fl = 1'b0;
            if (r < 62)      a = a + 28'd2;
            else if (r < 72) a = {a[27:3], 2'($urandom_range(0, 3)), 1'b0};
            else if (r < 80) a = a + 28'(8 * $urandom_range(1, 5));
            else if (r < 84) a = a - 28'd16;
            else if (r < 90) a = 28'($urandom) & 28'hFFFFFFE;
            else if (r < 95) do_flush();
            else begin
                fl = 1'b1;
                a  = a + 28'd2;
            end
            repeat ($urandom_range(0, 3)) @(posedge clk);
            issue(a, fl, 0);
            wait_resp();
        end

        repeat (20) @(posedge clk);
        done();
    end

endmodule
